// File: rtl/ball_paddle_collision.sv
// Ball motion and collision engine: moves the ball once per frame tick and bounces it
// off the side walls and both paddles. Define SPEEDUP_EN for a speed that grows with each paddle hit.
module ball_paddle_collision #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE1_Y  = 16,
  parameter int PADDLE2_Y  = 456,
  parameter int PADDLE_H   = 8,
  parameter int BALL_SPEED = 4,
  parameter int SERVE_X    = 316,
  parameter int SERVE_Y    = 236,
  parameter int HIT_CYCLES = 4,
  parameter int MAX_SPEED  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       serve_dir,
  input  logic [9:0] paddle1_x,
  input  logic [9:0] paddle2_x,
  input  logic [9:0] paddle1_width,
  input  logic [9:0] paddle2_width,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] hit,
  output logic [1:0] miss,
  output logic       in_play
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVE   = 2'd1;
  localparam logic [1:0] S_SCORED = 2'd2;

  localparam int CW = $clog2(HIT_CYCLES + 1);

  localparam logic signed [11:0] P1_FACE = 12'(PADDLE1_Y + PADDLE_H);
  localparam logic signed [11:0] P2_FACE = 12'(PADDLE2_Y - BALL_SIZE);
  localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] BALL_SZ = 12'(BALL_SIZE);
  localparam logic signed [10:0] SERVE_X0 = 11'(SERVE_X);
  localparam logic signed [10:0] SERVE_Y0 = 11'(SERVE_Y);

  logic [1:0]           state_q, state_d;
  logic signed [10:0]   x_q, x_d, y_q, y_d;
  logic                 dx_q, dx_d, dy_q, dy_d;
  logic [1:0]           hit_q, hit_d, miss_q, miss_d, hit_req;
  logic [CW-1:0]        hit_cnt_q, hit_cnt_d;
  logic                 hit_accept;
  logic [10:0]          speed;

  // Comparisons run one bit wider than the stored positions so pad_x + width cannot wrap.
  logic signed [11:0]   xw, yw, spd, nx, x_new, p1_l, p1_r, p2_l, p2_r;
  logic                 x_flip, ov1, ov2;

  assign xw   = $signed({x_q[10], x_q});
  assign yw   = $signed({y_q[10], y_q});
  assign spd  = $signed({1'b0, speed});
  assign p1_l = $signed({2'b00, paddle1_x});
  assign p1_r = p1_l + $signed({2'b00, paddle1_width});
  assign p2_l = $signed({2'b00, paddle2_x});
  assign p2_r = p2_l + $signed({2'b00, paddle2_width});

  always_comb begin
    nx     = dx_q ? (xw + spd) : (xw - spd);
    x_new  = nx;
    x_flip = 1'b0;
    if (nx < 12'sd0) begin
      x_new  = 12'sd0;
      x_flip = 1'b1;
    end else if (nx > X_MAX) begin
      x_new  = X_MAX;
      x_flip = 1'b1;
    end
    ov1 = ((x_new + BALL_SZ) > p1_l) && (x_new < p1_r);
    ov2 = ((x_new + BALL_SZ) > p2_l) && (x_new < p2_r);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    miss_d  = 2'b00;
    hit_req = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (serve) begin
          state_d = S_MOVE;
          dy_d    = serve_dir;
          dx_d    = 1'b1;
        end
      end
      S_MOVE: begin
        if (frame_tick) begin
          x_d = x_new[10:0];
          if (x_flip) dx_d = ~dx_q;
          if (!dy_q) begin
            if ((yw >= P1_FACE) && ((yw - spd) < P1_FACE) && ov1) begin
              y_d     = P1_FACE[10:0];
              dy_d    = 1'b1;
              hit_req = 2'b10;
            end else if (yw < spd) begin
              state_d = S_SCORED;
              miss_d  = 2'b01;
            end else begin
              y_d = 11'(yw - spd);
            end
          end else begin
            if ((yw <= P2_FACE) && ((yw + spd) > P2_FACE) && ov2) begin
              y_d     = P2_FACE[10:0];
              dy_d    = 1'b0;
              hit_req = 2'b01;
            end else if ((yw + spd) > Y_MAX) begin
              state_d = S_SCORED;
              miss_d  = 2'b10;
            end else begin
              y_d = 11'(yw + spd);
            end
          end
        end
      end
      S_SCORED: begin
        x_d     = SERVE_X0;
        y_d     = SERVE_Y0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request is dropped while a pulse is still running, guaranteeing a 00 gap between hits.
  assign hit_accept = (hit_req != 2'b00) && (hit_cnt_q == '0);

  always_comb begin
    hit_d     = hit_q;
    hit_cnt_d = hit_cnt_q;
    if (hit_accept) begin
      hit_d     = hit_req;
      hit_cnt_d = CW'(HIT_CYCLES);
    end else if (hit_cnt_q != '0) begin
      hit_cnt_d = hit_cnt_q - CW'(1);
      if (hit_cnt_q == CW'(1)) hit_d = 2'b00;
    end
  end

`ifdef SPEEDUP_EN
  logic [10:0] speed_q, speed_d;
  logic        serve_accept;

  assign serve_accept = (state_q == S_IDLE) && serve;

  always_comb begin
    speed_d = speed_q;
    if (serve_accept) speed_d = 11'(BALL_SPEED);
    else if (hit_accept && (speed_q < 11'(MAX_SPEED))) speed_d = speed_q + 11'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) speed_q <= 11'(BALL_SPEED);
    else       speed_q <= speed_d;
  end

  assign speed = speed_q;
`else
  // Fixed speed; the ceiling only matters if the configuration puts it below the base speed.
  assign speed = 11'((BALL_SPEED < MAX_SPEED) ? BALL_SPEED : MAX_SPEED);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= SERVE_X0;
      y_q       <= SERVE_Y0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b0;
      hit_q     <= 2'b00;
      miss_q    <= 2'b00;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign ball_x  = x_q[9:0];
  assign ball_y  = y_q[9:0];
  assign hit     = hit_q;
  assign miss    = miss_q;
  assign in_play = (state_q == S_MOVE);

endmodule
